pattern_match_seq: RTL and testbench

- Parametrised, clocked successor to the fixed sum-of-product detector cells in the regression set.
- Registers an N_IN-bit primary-input vector and compares it against a runtime-loaded care-mask/value pair.
- Asserts po0 only after the match has held for HOLD consecutive cycles; counts qualified hits.
- Used as a stimulus/observation block in sequential regression tests.

---
 rtl/pattern_match_pkg.sv | 20 ++
 rtl/pattern_match_if.sv | 29 ++
 rtl/pattern_match_cmp.sv | 12 +
 rtl/pattern_match_seq.sv | 119 +++++++++++
 tb/tb_pattern_match_seq.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/pattern_match_pkg.sv
// Shared types and sizing helpers for the pattern-match detector family.
// Pure declarations: no latency, no flow control.
package pattern_match_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        DETECT = 2'd2
    } pm_state_e;

    // Width of the run counter: it must be able to hold the value HOLD itself.
    function automatic int run_w(input int hold);
        return $clog2(hold + 1);
    endfunction

    function automatic logic [31:0] cnt_max(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/pattern_match_if.sv
// Pattern-match bus: input vector, config handshake, detect outputs and hit counter.
// Config uses valid/ready; all other signals are level signals sampled every cycle.
interface pattern_match_if #(
    parameter int N_IN  = 10,
    parameter int CNT_W = 8
);
    logic [N_IN-1:0]  pi;
    logic             en;
    logic             clr;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [N_IN-1:0]  cfg_mask;
    logic [N_IN-1:0]  cfg_value;
    logic             cfg_inv;
    logic             po0;
    logic             po_pulse;
    logic [CNT_W-1:0] hit_cnt;
    logic             cnt_sat;

    modport master (
        output pi, en, clr, cfg_valid, cfg_mask, cfg_value, cfg_inv,
        input  cfg_ready, po0, po_pulse, hit_cnt, cnt_sat
    );

    modport slave (
        input  pi, en, clr, cfg_valid, cfg_mask, cfg_value, cfg_inv,
        output cfg_ready, po0, po_pulse, hit_cnt, cnt_sat
    );
endinterface

// File: rtl/pattern_match_cmp.sv
// Masked equality of a registered vector against a care-mask/value pair.
// Combinational, zero latency; no flow control. An all-zero mask always matches.
module pattern_match_cmp #(
    parameter int N_IN = 10
) (
    input  logic [N_IN-1:0] pi_q,
    input  logic [N_IN-1:0] mask,
    input  logic [N_IN-1:0] value,
    output logic            match
);
    assign match = &(~mask | ~(pi_q ^ value));
endmodule

// File: rtl/pattern_match_seq.sv
// Registered pattern detector: po0 rises HOLD edges after the first matching pi_q, counts detects.
// Config is accepted only in IDLE (cfg_ready low otherwise); pi is never back-pressured.
module pattern_match_seq
    import pattern_match_pkg::*;
#(
    parameter int N_IN  = 10,
    parameter int HOLD  = 3,
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    pattern_match_if.slave bus
);
    localparam int               RUN_W   = run_w(HOLD);
    localparam logic [RUN_W-1:0] HOLD_V  = RUN_W'(HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic [N_IN-1:0]  pi_q, mask_q, value_q;
    logic             inv_q;
    pm_state_e        state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d, run_inc;
    logic             pulse_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             sat_q, sat_d;
    logic             match, cfg_fire, enter_det;

    pattern_match_cmp #(.N_IN(N_IN)) u_cmp (
        .pi_q  (pi_q),
        .mask  (mask_q),
        .value (value_q),
        .match (match)
    );

    assign run_inc = run_q + 1'b1;
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        cfg_fire = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_fire = bus.cfg_valid;
                if (bus.en) begin
                    state_d = ARMED;
                    run_d   = '0;
                end
            end
            ARMED: begin
                if (!bus.en) begin
                    state_d = IDLE;
                    run_d   = '0;
                end else if (match) begin
                    if (run_inc == HOLD_V) state_d = DETECT;
                    else                   run_d   = run_inc;
                end else begin
                    run_d = '0;
                end
            end
            DETECT: begin
                // Losing the match forces a full re-qualification of HOLD cycles.
                if (!bus.en || !match) begin
                    state_d = bus.en ? ARMED : IDLE;
                    run_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                run_d   = '0;
            end
        endcase
    end

    assign enter_det = (state_q == ARMED) && (state_d == DETECT);

    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (bus.clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (enter_det && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pi_q    <= '0;
            mask_q  <= '0;
            value_q <= '0;
            inv_q   <= 1'b0;
            state_q <= IDLE;
            run_q   <= '0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            pi_q    <= bus.pi;
            state_q <= state_d;
            run_q   <= run_d;
            pulse_q <= enter_det;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            if (cfg_fire) begin
                mask_q  <= bus.cfg_mask;
                value_q <= bus.cfg_value;
                inv_q   <= bus.cfg_inv;
            end
        end
    end

    assign bus.cfg_ready = (state_q == IDLE);
    assign bus.po0       = (state_q == DETECT) ^ inv_q;
    assign bus.po_pulse  = pulse_q;
    assign bus.hit_cnt   = cnt_q;
    assign bus.cnt_sat   = sat_q;
endmodule

// File: tb/tb_pattern_match_seq.sv
// Directed bench for pattern_match_seq with N_IN=10, HOLD=3, CNT_W=2.
// Each table row is driven for one edge and the outputs are compared just after it.
module tb_pattern_match_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pattern_match_if #(.N_IN(10), .CNT_W(2)) bus ();

    pattern_match_seq #(.N_IN(10), .HOLD(3), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       en;
        logic       clr;
        logic       cv;
        logic [9:0] mask;
        logic [9:0] value;
        logic       inv;
        logic [9:0] pi;
        logic       e_po0;
        logic       e_pul;
        logic [1:0] e_cnt;
        logic       e_sat;
        logic       e_rdy;
    } vec_t;

    localparam int NV = 36;
    vec_t vecs [NV];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input int en, input int clr, input int cv, input int m,
                                input int val, input int inv, input int p, input int po,
                                input int pul, input int cnt, input int sat, input int rdy);
        vec_t r;
        r.en    = en[0];
        r.clr   = clr[0];
        r.cv    = cv[0];
        r.mask  = m[9:0];
        r.value = val[9:0];
        r.inv   = inv[0];
        r.pi    = p[9:0];
        r.e_po0 = po[0];
        r.e_pul = pul[0];
        r.e_cnt = cnt[1:0];
        r.e_sat = sat[0];
        r.e_rdy = rdy[0];
        return r;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_outs(input int idx, input logic po, input logic pul, input logic [1:0] cnt,
                            input logic sat, input logic rdy);
        chk("po0",       idx, 32'(bus.po0),       32'(po));
        chk("po_pulse",  idx, 32'(bus.po_pulse),  32'(pul));
        chk("hit_cnt",   idx, 32'(bus.hit_cnt),   32'(cnt));
        chk("cnt_sat",   idx, 32'(bus.cnt_sat),   32'(sat));
        chk("cfg_ready", idx, 32'(bus.cfg_ready), 32'(rdy));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //              en clr cv mask   value  inv pi      po0 pul cnt sat rdy
        vecs[0]  = mk(1, 0, 1, 'h3FF, 'h2C6, 0, 'h2C6,  0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 'h3FF, 'h2C6, 0, 'h2C6,  0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 'h3FF, 'h2C6, 0, 'h2C6,  0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 0, 'h3FF, 'h2C6, 0, 'h2C6,  1, 1, 1, 0, 0);
        vecs[4]  = mk(1, 0, 0, 'h3FF, 'h2C6, 0, 'h2C6,  1, 0, 1, 0, 0);
        // broken run: two matches, one miss, then three fresh matches
        vecs[5]  = mk(1, 0, 0, 'h3FF, 'h2C6, 0, 'h2C7,  1, 0, 1, 0, 0);
        vecs[6]  = mk(1, 0, 0, 'h3FF, 'h2C6, 0, 'h2C6,  0, 0, 1, 0, 0);
        vecs[7]  = mk(1, 0, 0, 'h3FF, 'h2C6, 0, 'h2C6,  0, 0, 1, 0, 0);
        vecs[8]  = mk(1, 0, 0, 'h3FF, 'h2C6, 0, 'h2C7,  0, 0, 1, 0, 0);
        vecs[9]  = mk(1, 0, 0, 'h3FF, 'h2C6, 0, 'h2C6,  0, 0, 1, 0, 0);
        vecs[10] = mk(1, 0, 0, 'h3FF, 'h2C6, 0, 'h2C6,  0, 0, 1, 0, 0);
        vecs[11] = mk(1, 0, 0, 'h3FF, 'h2C6, 0, 'h2C6,  0, 0, 1, 0, 0);
        vecs[12] = mk(1, 0, 0, 'h3FF, 'h2C6, 0, 'h2C6,  1, 1, 2, 0, 0);
        vecs[13] = mk(0, 0, 0, 'h3FF, 'h2C6, 0, 'h2C6,  0, 0, 2, 0, 1);
        // mask + inverted polarity; third detect saturates the 2-bit counter
        vecs[14] = mk(0, 0, 1, 'h00F, 'h005, 1, 'h3F5,  1, 0, 2, 0, 1);
        vecs[15] = mk(1, 0, 0, 'h00F, 'h005, 1, 'h3F5,  1, 0, 2, 0, 0);
        vecs[16] = mk(1, 0, 0, 'h00F, 'h005, 1, 'h3F5,  1, 0, 2, 0, 0);
        vecs[17] = mk(1, 0, 0, 'h00F, 'h005, 1, 'h3F5,  1, 0, 2, 0, 0);
        vecs[18] = mk(1, 0, 0, 'h00F, 'h005, 1, 'h3F5,  0, 1, 3, 1, 0);
        vecs[19] = mk(1, 0, 0, 'h00F, 'h005, 1, 'h3F5,  0, 0, 3, 1, 0);
        // config offered during DETECT is held off until IDLE
        vecs[20] = mk(1, 0, 1, 'h00F, 'h006, 0, 'h3F5,  0, 0, 3, 1, 0);
        vecs[21] = mk(1, 0, 1, 'h00F, 'h006, 0, 'h3F5,  0, 0, 3, 1, 0);
        vecs[22] = mk(0, 0, 1, 'h00F, 'h006, 0, 'h3F5,  1, 0, 3, 1, 1);
        vecs[23] = mk(0, 0, 1, 'h00F, 'h006, 0, 'h3F5,  0, 0, 3, 1, 1);
        vecs[24] = mk(0, 0, 0, 'h00F, 'h006, 0, 'h3F6,  0, 0, 3, 1, 1);
        vecs[25] = mk(1, 0, 0, 'h00F, 'h006, 0, 'h3F6,  0, 0, 3, 1, 0);
        vecs[26] = mk(1, 0, 0, 'h00F, 'h006, 0, 'h3F6,  0, 0, 3, 1, 0);
        vecs[27] = mk(1, 0, 0, 'h00F, 'h006, 0, 'h3F6,  0, 0, 3, 1, 0);
        vecs[28] = mk(1, 0, 0, 'h00F, 'h006, 0, 'h3F6,  1, 1, 3, 1, 0);
        // fifth detect coincides with clr
        vecs[29] = mk(1, 0, 0, 'h00F, 'h006, 0, 'h3F5,  1, 0, 3, 1, 0);
        vecs[30] = mk(1, 0, 0, 'h00F, 'h006, 0, 'h3F6,  0, 0, 3, 1, 0);
        vecs[31] = mk(1, 0, 0, 'h00F, 'h006, 0, 'h3F6,  0, 0, 3, 1, 0);
        vecs[32] = mk(1, 0, 0, 'h00F, 'h006, 0, 'h3F6,  0, 0, 3, 1, 0);
        vecs[33] = mk(1, 1, 0, 'h00F, 'h006, 0, 'h3F6,  1, 1, 0, 0, 0);
        vecs[34] = mk(1, 0, 0, 'h00F, 'h006, 0, 'h3F6,  1, 0, 0, 0, 0);
        vecs[35] = mk(0, 0, 0, 'h00F, 'h006, 0, 'h3F6,  0, 0, 0, 0, 1);

        rst_n         = 1'b0;
        bus.pi        = '0;
        bus.en        = 1'b0;
        bus.clr       = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_mask  = '0;
        bus.cfg_value = '0;
        bus.cfg_inv   = 1'b0;
        #1;
        chk_outs(-1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        #11;
        rst_n = 1'b1;
        #1;
        chk("cfg_ready_after_release", -1, 32'(bus.cfg_ready), 32'd1);

        for (int i = 0; i < NV; i++) begin
            bus.en        = vecs[i].en;
            bus.clr       = vecs[i].clr;
            bus.cfg_valid = vecs[i].cv;
            bus.cfg_mask  = vecs[i].mask;
            bus.cfg_value = vecs[i].value;
            bus.cfg_inv   = vecs[i].inv;
            bus.pi        = vecs[i].pi;
            step();
            chk_outs(i, vecs[i].e_po0, vecs[i].e_pul, vecs[i].e_cnt, vecs[i].e_sat, vecs[i].e_rdy);
        end

        // Mid-cycle reset while in DETECT with a nonzero count.
        bus.en = 1'b1;
        bus.pi = 10'h3F6;
        repeat (4) step();
        chk("pre_reset_po0", 100, 32'(bus.po0), 32'd1);
        chk("pre_reset_cnt", 100, 32'(bus.hit_cnt), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_outs(101, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b1;

        // Mask returns to zero on reset, so any pi qualifies after a fresh HOLD run.
        bus.pi = 10'h155;
        repeat (3) step();
        chk("post_reset_po0_early", 102, 32'(bus.po0), 32'd0);
        step();
        chk_outs(103, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0);

        bus.en = 1'b0;
        step();
        chk("final_idle_ready", 104, 32'(bus.cfg_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
